// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM state encodings,
// default response timeout and the fixed-priority pick helper.
package dmem_arbiter_pkg;

    // Transaction sequencer states (2-bit encoding shared by the arbiter slice).
    typedef enum logic [1:0] {
        DMEM_ARB_IDLE  = 2'd0,
        DMEM_ARB_ISSUE = 2'd1,
        DMEM_ARB_WAIT  = 2'd2,
        DMEM_ARB_RESP  = 2'd3
    } dmem_arb_state_e;

    // Default number of WAIT cycles before a stalled RAM is reported as an error.
    localparam int DMEM_ARB_TIMEOUT_DEF = 15;

    // Port 0 beats port 1; returns a one-hot winner (or zero with no request).
    function automatic logic [1:0] fixed_pick(input logic [1:0] req);
        if (req[0]) begin
            return 2'b01;
        end else if (req[1]) begin
            return 2'b10;
        end
        return 2'b00;
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-requester arbiter producing a one-hot winner.
// Build option: DMEM_ARB_RR_EN selects round-robin between contending ports;
// without it port 0 always wins and the last-grant pointer is not built.
module rr_arb2
    import dmem_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    input  logic       i_take,
    output logic [1:0] o_win
);

`ifdef DMEM_ARB_RR_EN
    // 1 = port 1 was granted last; reset value steers the first contest to port 0.
    logic r_last;

    // Contended requests go to the port that was not served last.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        o_win = fixed_pick(i_req);
        if (i_req == 2'b11) begin
            o_win = r_last ? 2'b01 : 2'b10;
        end
    end

    // Remember which port won each accepted grant.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            r_last <= 1'b1;
        end else if (i_take && (o_win != 2'b00)) begin
            r_last <= o_win[1];
        end
    end
`else
    // Fixed priority needs no state; clock, reset and take are intentionally unused.
    logic w_unused;
    assign w_unused = clk ^ rst ^ i_take;
    assign o_win    = fixed_pick(i_req);
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of data_ram: grants one requester per
// transaction, issues a one-cycle RAM enable, waits for the response (with
// timeout) and returns done/err/rdata to the granted port.
// Build option: DMEM_ARB_RR_EN (round-robin arbitration, see rr_arb2).
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = DMEM_ARB_TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_p0_req,
    input  logic              i_p1_req,
    input  logic              i_p0_wr,
    input  logic              i_p1_wr,
    input  logic [ADDR_W-1:0] i_p0_addr,
    input  logic [ADDR_W-1:0] i_p1_addr,
    input  logic [DATA_W-1:0] i_p0_wdata,
    input  logic [DATA_W-1:0] i_p1_wdata,
    output logic              o_p0_gnt,
    output logic              o_p1_gnt,
    output logic              o_p0_done,
    output logic              o_p1_done,
    output logic              o_p0_err,
    output logic              o_p1_err,
    output logic [DATA_W-1:0] o_p0_rdata,
    output logic [DATA_W-1:0] o_p1_rdata,
    output logic              o_mem_en,
    output logic              o_mem_rd,
    output logic              o_mem_wr,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    input  logic              i_mem_rdy,
    input  logic              i_mem_vld
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    dmem_arb_state_e   r_state;
    dmem_arb_state_e   w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_port;      // granted port of the current transaction
    logic              r_wr;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_err;
    logic [DATA_W-1:0] r_p0_rdata;
    logic [DATA_W-1:0] r_p1_rdata;

    logic [1:0]        w_win;
    logic              w_take;
    logic              w_fin;
    logic              w_err;
    logic              w_upd;
    logic [DATA_W-1:0] w_rdval;
    logic              w_done;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .i_req  ({i_p1_req, i_p0_req}),
        .i_take (w_take),
        .o_win  (w_win)
    );

    assign w_take = (r_state == DMEM_ARB_IDLE) && (w_win != 2'b00);
    assign w_fin  = (r_state == DMEM_ARB_WAIT) &&
                    (i_mem_rdy || (r_cnt == CNT_W'(TIMEOUT)));

    // State register; reset aborts any transaction without a done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= DMEM_ARB_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode: IDLE -> ISSUE -> WAIT (until rdy/timeout) -> RESP -> IDLE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            DMEM_ARB_IDLE:  if (w_take) w_next = DMEM_ARB_ISSUE;
            DMEM_ARB_ISSUE: w_next = DMEM_ARB_WAIT;
            DMEM_ARB_WAIT:  if (w_fin) w_next = DMEM_ARB_RESP;
            DMEM_ARB_RESP:  w_next = DMEM_ARB_IDLE;
            default:        w_next = DMEM_ARB_IDLE;
        endcase
    end

    // Capture the winner's request fields at grant time.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the request latches are reset too, since they drive o_mem_addr/wdata directly.
        if (rst) begin
            r_port  <= 1'b0;
            r_wr    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_take) begin
            r_port  <= w_win[1] & ~w_win[0];
            r_wr    <= w_win[1] ? i_p1_wr    : i_p0_wr;
            r_addr  <= w_win[1] ? i_p1_addr  : i_p0_addr;
            r_wdata <= w_win[1] ? i_p1_wdata : i_p0_wdata;
        end
    end

    // WAIT cycle counter: cleared while issuing, saturates at TIMEOUT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_state == DMEM_ARB_ISSUE) begin
            r_cnt <= '0;
        end else if ((r_state == DMEM_ARB_WAIT) && (r_cnt != CNT_W'(TIMEOUT))) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Classify the end of WAIT: good read, read without valid, write ack or timeout.
    always_comb begin
        w_err   = 1'b0;
        w_upd   = 1'b0;
        w_rdval = '0;
        if (i_mem_rdy) begin
            if (!r_wr) begin
                w_upd = 1'b1;
                if (i_mem_vld) begin
                    w_rdval = i_mem_rdata;
                end else begin
                    w_err = 1'b1;
                end
            end
        end else begin
            w_err = 1'b1;
            w_upd = 1'b1;
        end
    end

    // Response registers; only the granted port's read data changes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err      <= 1'b0;
            r_p0_rdata <= '0;
            r_p1_rdata <= '0;
        end else if (w_fin) begin
            r_err <= w_err;
            if (w_upd && r_port) begin
                r_p1_rdata <= w_rdval;
            end else if (w_upd) begin
                r_p0_rdata <= w_rdval;
            end
        end
    end

    // Outputs decode registered state only, so no input reaches an output combinationally.
    assign o_mem_en    = (r_state == DMEM_ARB_ISSUE);
    assign o_mem_rd    = o_mem_en & ~r_wr;
    assign o_mem_wr    = o_mem_en &  r_wr;
    assign o_mem_addr  = r_addr;
    assign o_mem_wdata = r_wdata;
    assign o_p0_gnt    = o_mem_en & ~r_port;
    assign o_p1_gnt    = o_mem_en &  r_port;
    assign w_done      = (r_state == DMEM_ARB_RESP);
    assign o_p0_done   = w_done & ~r_port;
    assign o_p1_done   = w_done &  r_port;
    assign o_p0_err    = o_p0_done & r_err;
    assign o_p1_err    = o_p1_done & r_err;
    assign o_p0_rdata  = r_p0_rdata;
    assign o_p1_rdata  = r_p1_rdata;

endmodule
